// File: rtl/pipe_hazard_ctl_if.sv
// Signal bundle between the 5-stage datapath and its hazard/sequencing controller.
// The datapath is the master (supplies stage info, consumes controls); the controller is the slave.
interface pipe_hazard_ctl_if;
  logic [2:0] id_rX;
  logic [2:0] id_rY;
  logic       id_uses_rX;
  logic       id_uses_rY;
  logic       id_halt;
  logic [2:0] ex_rX;
  logic [2:0] ex_rY;
  logic [2:0] ex_rO;
  logic       ex_wr;
  logic       ex_is_load;
  logic       ex_branch_taken;
  logic [2:0] mem_rO;
  logic       mem_wr;
  logic [2:0] wb_rO;
  logic       wb_wr;
  logic       dmem_busy;

  logic       pc_write_en;
  logic       ifid_write_en;
  logic       ifid_flush;
  logic       idex_write_en;
  logic       idex_bubble;
  logic [1:0] fwd_x_sel;
  logic [1:0] fwd_y_sel;
  logic       halted;

  modport master (
    output id_rX, id_rY, id_uses_rX, id_uses_rY, id_halt,
           ex_rX, ex_rY, ex_rO, ex_wr, ex_is_load, ex_branch_taken,
           mem_rO, mem_wr, wb_rO, wb_wr, dmem_busy,
    input  pc_write_en, ifid_write_en, ifid_flush, idex_write_en,
           idex_bubble, fwd_x_sel, fwd_y_sel, halted
  );

  modport slave (
    input  id_rX, id_rY, id_uses_rX, id_uses_rY, id_halt,
           ex_rX, ex_rY, ex_rO, ex_wr, ex_is_load, ex_branch_taken,
           mem_rO, mem_wr, wb_rO, wb_wr, dmem_busy,
    output pc_write_en, ifid_write_en, ifid_flush, idex_write_en,
           idex_bubble, fwd_x_sel, fwd_y_sel, halted
  );
endinterface

// File: rtl/pipe_hazard_ctl.sv
// Pipeline sequencer: load-use stall, data-memory wait, branch flush and halt drain,
// plus EX-stage operand forwarding selects.
module pipe_hazard_ctl #(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctl_if.slave bus
);

  typedef enum logic [2:0] {RUN, LDUSE, MEMWAIT, DRAIN, HALTED} state_t;

  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  state_t     state, ret_state, eff_state, nxt_state, nxt_ret_state;
  logic [2:0] cnt, nxt_cnt;
  logic       halted_q;
  logic       load_use;
  logic       pc_we, ifid_we, idex_we, flush, bubble;

  assign load_use = bus.ex_is_load & bus.ex_wr &
                    ((bus.id_uses_rX & (bus.id_rX == bus.ex_rO)) |
                     (bus.id_uses_rY & (bus.id_rY == bus.ex_rO)));

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    nxt_state     = state;
    nxt_ret_state = ret_state;
    nxt_cnt       = cnt;
    pc_we         = 1'b1;
    ifid_we       = 1'b1;
    idex_we       = 1'b1;
    flush         = 1'b0;
    bubble        = 1'b0;

    // Once memory is ready, the MEMWAIT exit cycle behaves exactly as the interrupted state.
    eff_state = (state == MEMWAIT) ? ret_state : state;

    if (state == HALTED) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      idex_we = 1'b0;
    end else if (bus.dmem_busy) begin
      pc_we         = 1'b0;
      ifid_we       = 1'b0;
      idex_we       = 1'b0;
      nxt_state     = MEMWAIT;
      nxt_ret_state = eff_state;
    end else if (bus.ex_branch_taken) begin
      flush     = 1'b1;
      bubble    = 1'b1;
      nxt_state = RUN;
      nxt_cnt   = 3'd0;
    end else begin
      unique case (eff_state)
        RUN: begin
          if (load_use) begin
            pc_we     = 1'b0;
            ifid_we   = 1'b0;
            bubble    = 1'b1;
            nxt_state = LDUSE;
          end else if (bus.id_halt) begin
            nxt_state = DRAIN;
            nxt_cnt   = 3'd0;
          end else begin
            nxt_state = RUN;
          end
        end
        LDUSE: begin
          // The single stall cycle has already elapsed; the same hazard is not re-detected.
          if (bus.id_halt) begin
            nxt_state = DRAIN;
            nxt_cnt   = 3'd0;
          end else begin
            nxt_state = RUN;
          end
        end
        DRAIN: begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          bubble  = 1'b1;
          nxt_cnt = cnt + 3'd1;
          if (cnt == DRAIN_LAST) nxt_state = HALTED;
        end
        default: nxt_state = RUN;
      endcase
    end

    if (rst) begin
      pc_we   = 1'b1;
      ifid_we = 1'b1;
      idex_we = 1'b1;
      flush   = 1'b0;
      bubble  = 1'b0;
    end
  end

  always_comb begin
    bus.fwd_x_sel = 2'b00;
    bus.fwd_y_sel = 2'b00;
    if (!rst) begin
      if (bus.mem_wr && bus.mem_rO == bus.ex_rX)     bus.fwd_x_sel = 2'b01;
      else if (bus.wb_wr && bus.wb_rO == bus.ex_rX)  bus.fwd_x_sel = 2'b10;
      if (bus.mem_wr && bus.mem_rO == bus.ex_rY)     bus.fwd_y_sel = 2'b01;
      else if (bus.wb_wr && bus.wb_rO == bus.ex_rY)  bus.fwd_y_sel = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state     <= RUN;
      ret_state <= RUN;
      cnt       <= 3'd0;
      halted_q  <= 1'b0;
    end else begin
      state     <= nxt_state;
      ret_state <= nxt_ret_state;
      cnt       <= nxt_cnt;
      halted_q  <= (nxt_state == HALTED);
    end
  end

  assign bus.pc_write_en   = pc_we;
  assign bus.ifid_write_en = ifid_we;
  assign bus.ifid_flush    = flush;
  assign bus.idex_write_en = idex_we;
  assign bus.idex_bubble   = bubble;
  assign bus.halted        = halted_q;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Randomized and directed bench for pipe_hazard_ctl against a behavioural model in which
// a memory wait simply freezes the sequencer and a halt starts a countdown.
module tb_pipe_hazard_ctl;

  localparam int DC = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctl_if bus ();

  pipe_hazard_ctl #(.DRAIN_CYCLES(DC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: halted flag, drain cycles still to go (0 = not draining), "stall already taken" flag.
  bit m_halted   = 1'b0;
  int m_drain    = 0;
  bit m_after_ld = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int fwd_of(input logic [2:0] r);
    if (bus.mem_wr && bus.mem_rO == r) return 1;
    if (bus.wb_wr && bus.wb_rO == r)   return 2;
    return 0;
  endfunction

  task automatic clear_inputs();
    bus.id_rX = 0; bus.id_rY = 0; bus.id_uses_rX = 0; bus.id_uses_rY = 0; bus.id_halt = 0;
    bus.ex_rX = 0; bus.ex_rY = 0; bus.ex_rO = 0; bus.ex_wr = 0; bus.ex_is_load = 0;
    bus.ex_branch_taken = 0; bus.mem_rO = 0; bus.mem_wr = 0; bus.wb_rO = 0; bus.wb_wr = 0;
    bus.dmem_busy = 0;
  endtask

  // One clock: check outputs at the negedge against the model, advance the model, pass the posedge.
  task automatic step();
    bit hz;
    int e_pc, e_ifid, e_idex, e_fl, e_bb, e_fx, e_fy;
    @(negedge clk);
    hz = bus.ex_is_load && bus.ex_wr &&
         ((bus.id_uses_rX && bus.id_rX == bus.ex_rO) || (bus.id_uses_rY && bus.id_rY == bus.ex_rO));
    e_fx = rst ? 0 : fwd_of(bus.ex_rX);
    e_fy = rst ? 0 : fwd_of(bus.ex_rY);
    e_pc = 1; e_ifid = 1; e_idex = 1; e_fl = 0; e_bb = 0;
    check("halted", bus.halted, m_halted);
    if (rst) begin
      m_halted = 0; m_drain = 0; m_after_ld = 0;
    end else if (m_halted || bus.dmem_busy) begin
      e_pc = 0; e_ifid = 0; e_idex = 0;
    end else if (bus.ex_branch_taken) begin
      e_fl = 1; e_bb = 1; m_drain = 0; m_after_ld = 0;
    end else if (m_drain > 0) begin
      e_pc = 0; e_ifid = 0; e_bb = 1;
      m_drain--;
      if (m_drain == 0) m_halted = 1;
    end else if (hz && !m_after_ld) begin
      e_pc = 0; e_ifid = 0; e_bb = 1; m_after_ld = 1;
    end else begin
      if (bus.id_halt) m_drain = DC;
      m_after_ld = 0;
    end
    check("pc_we", bus.pc_write_en, e_pc);
    check("ifid_we", bus.ifid_write_en, e_ifid);
    check("idex_we", bus.idex_write_en, e_idex);
    check("ifid_flush", bus.ifid_flush, e_fl);
    check("idex_bubble", bus.idex_bubble, e_bb);
    check("fwd_x", bus.fwd_x_sel, e_fx);
    check("fwd_y", bus.fwd_y_sel, e_fy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  task automatic set_load_use();
    bus.ex_is_load = 1; bus.ex_wr = 1; bus.ex_rO = 3; bus.id_uses_rX = 1; bus.id_rX = 3;
  endtask

  // Steps until halted rises; n is the count of clocks since the HALT cycle.
  task automatic wait_halted(inout int n);
    while (!bus.halted && n < 40) begin
      step(); n++;
    end
  endtask

  initial begin
    int n;
    clear_inputs();
    rst = 1;
    step(); step();
    rst = 0;

    // Load-use: one stall, then no re-detection with the same inputs held.
    set_load_use(); step(); step();
    clear_inputs(); step();

    // Forwarding priority and no-match.
    bus.ex_rX = 2; bus.ex_rY = 5; bus.mem_wr = 1; bus.mem_rO = 2; bus.wb_wr = 1; bus.wb_rO = 2;
    step();
    bus.mem_wr = 0; step();
    clear_inputs();

    // Branch beats load-use.
    set_load_use(); bus.ex_branch_taken = 1; step();
    clear_inputs(); step();

    // Halt drain latency.
    bus.id_halt = 1; step(); bus.id_halt = 0; n = 1;
    wait_halted(n);
    check("halt_latency", n, DC + 1);
    bus.dmem_busy = 1; step(); bus.dmem_busy = 0;
    do_reset();

    // Halt drain with a two-cycle memory wait.
    bus.id_halt = 1; step(); bus.id_halt = 0; n = 1;
    step(); n++;
    bus.dmem_busy = 1; step(); step(); n += 2; bus.dmem_busy = 0;
    wait_halted(n);
    check("halt_busy_latency", n, DC + 3);
    do_reset();

    // Branch squashes the drain on its first cycle.
    bus.id_halt = 1; step(); bus.id_halt = 0;
    bus.ex_branch_taken = 1; step(); bus.ex_branch_taken = 0;
    for (int i = 0; i < DC + 2; i++) step();

    // Reset on the second drain cycle.
    bus.id_halt = 1; step(); bus.id_halt = 0;
    step();
    rst = 1; step(); rst = 0;
    step(); step();

    // Randomized traffic with small register numbers so matches are frequent.
    for (int i = 0; i < 4000; i++) begin
      bus.id_rX = 3'($urandom_range(0, 3));
      bus.id_rY = 3'($urandom_range(0, 3));
      bus.id_uses_rX = 1'($urandom);
      bus.id_uses_rY = 1'($urandom);
      bus.id_halt = ($urandom_range(0, 99) < 6);
      bus.ex_rX = 3'($urandom_range(0, 3));
      bus.ex_rY = 3'($urandom_range(0, 3));
      bus.ex_rO = 3'($urandom_range(0, 3));
      bus.ex_wr = 1'($urandom);
      bus.ex_is_load = 1'($urandom);
      bus.ex_branch_taken = ($urandom_range(0, 99) < 8);
      bus.mem_rO = 3'($urandom_range(0, 3));
      bus.mem_wr = 1'($urandom);
      bus.wb_rO = 3'($urandom_range(0, 3));
      bus.wb_wr = 1'($urandom);
      bus.dmem_busy = ($urandom_range(0, 99) < 15);
      rst = ($urandom_range(0, 99) < 2);
      step();
    end
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctl.md
Name: pipe_hazard_ctl

Overview:
Central pipeline sequencer for the 5-stage core. It drives the write-enable, bubble and flush controls of the PC, IF/ID and ID/EX pipeline registers, and the operand-forwarding selects for the EX stage. It owns a small FSM that handles load-use stalls, data-memory wait, branch flush and halt drain, and it asserts `halted` once the pipeline is empty after a HALT.

Parameters:
- DRAIN_CYCLES, 3: cycles after HALT enters EX before `halted` asserts (covers EX, MEM, WB). Legal range 1..7.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- id_rX  in  3  ID-stage source X register number
- id_rY  in  3  ID-stage source Y register number
- id_uses_rX  in  1  ID instruction reads rX
- id_uses_rY  in  1  ID instruction reads rY
- id_halt  in  1  ID instruction is HALT
- ex_rX  in  3  EX-stage source X (from ID/EX)
- ex_rY  in  3  EX-stage source Y (from ID/EX)
- ex_rO  in  3  EX-stage destination
- ex_wr  in  1  EX instruction writes the register file
- ex_is_load  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- mem_rO  in  3  MEM-stage destination
- mem_wr  in  1  MEM instruction writes the register file
- wb_rO  in  3  WB-stage destination
- wb_wr  in  1  WB instruction writes the register file
- dmem_busy  in  1  data memory not ready this cycle
- pc_write_en  out  1  PC register enable
- ifid_write_en  out  1  IF/ID enable
- ifid_flush  out  1  IF/ID loads a NOP
- idex_write_en  out  1  ID/EX enable
- idex_bubble  out  1  ID/EX loads a NOP (all control fields zero)
- fwd_x_sel  out  2  EX operand X source: 00 regfile, 01 MEM, 10 WB
- fwd_y_sel  out  2  same, for operand Y
- halted  out  1  pipeline drained after HALT (registered)

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- FSM states: RUN, LDUSE, MEMWAIT, DRAIN, HALTED. Drain counter is 3 bits.
- Reset: state=RUN, counter=0, halted=0.
- While rst is high: all write enables =1, flush/bubble =0, fwd selects =00.
- Enables, flush, bubble and fwd selects are combinational from state and inputs. `halted` and the state are registered.
- Control priority, highest first (RUN, LDUSE and DRAIN):
  1. dmem_busy
  2. ex_branch_taken
  3. load-use hazard
  4. id_halt
- dmem_busy=1, in any state except HALTED:
  - All enables =0, flush=0, bubble=0.
  - Go to MEMWAIT, remembering the interrupted state; the counter holds.
  - Leave MEMWAIT on the first cycle dmem_busy=0, returning to the remembered state. That cycle is evaluated as that state.
- Branch (ex_branch_taken=1, not busy):
  - pc_write_en=1, ifid_flush=1, idex_bubble=1.
  - Next state=RUN. This applies in DRAIN too: it squashes the younger HALT and clears the counter.
- Load-use hazard, defined as ex_is_load & ex_wr & ((id_uses_rX & id_rX==ex_rO) | (id_uses_rY & id_rY==ex_rO)), evaluated in RUN only:
  - pc_write_en=0, ifid_write_en=0, idex_bubble=1.
  - Go to LDUSE.
- LDUSE:
  - Exactly one stall cycle has elapsed; no re-detection.
  - Normal enables; evaluate id_halt as in RUN.
  - Next state=RUN, or DRAIN if id_halt.
- Halt (RUN or LDUSE, id_halt=1, nothing higher):
  - All enables =1 so HALT enters ID/EX.
  - Next state=DRAIN, counter=0.
- DRAIN:
  - pc_write_en=0, ifid_write_en=0, idex_write_en=1, idex_bubble=1.
  - Counter increments each non-busy cycle.
  - When counter==DRAIN_CYCLES-1, next state=HALTED.
- HALTED:
  - All enables =0, halted=1. Inputs, including dmem_busy, are ignored until rst.
- Forwarding (all states, pure comparison):
  - fwd_x_sel=01 if mem_wr & mem_rO==ex_rX; else 10 if wb_wr & wb_rO==ex_rX; else 00. fwd_y_sel is the same using ex_rY.
  - MEM wins over WB. r0 gets no special treatment.
  - Selects are not gated by stall state.

Test Plan:
- Load-use: ex_is_load=1, ex_wr=1, ex_rO=3, id_uses_rX=1, id_rX=3 → exactly one cycle of pc_we=0, ifid_we=0, idex_bubble=1. The next cycle has all enables=1 with the same inputs held (LDUSE suppresses re-detection).
- Forwarding: ex_rX=2, mem_wr=1, mem_rO=2, wb_wr=1, wb_rO=2 → fwd_x_sel=01. With mem_wr=0 → 10. With ex_rY=5 and no match → fwd_y_sel=00.
- Branch vs. hazard: load-use hazard and ex_branch_taken=1 in the same cycle → pc_we=1, ifid_flush=1, idex_bubble=1; next state RUN (no LDUSE cycle).
- Halt drain: id_halt=1 in RUN, DRAIN_CYCLES=3 → halted rises 4 clocks later. A dmem_busy pulse of 2 cycles during DRAIN delays halted by exactly 2 cycles.
- Squash in drain: ex_branch_taken=1 on the first DRAIN cycle → ifid_flush=1, back to RUN, halted stays 0, pc_we=1.
- Reset mid-drain: assert rst on the second DRAIN cycle → next cycle state RUN, halted=0, all enables=1.
